prbs_lfsr_gen: RTL and testbench

PRBS_LFSR_GEN -- requirements
Module: prbs_lfsr_gen

---
 rtl/lfsr_pkg.sv | 60 ++++++
 rtl/lfsr_next.sv | 28 ++
 rtl/prbs_lfsr_gen.sv | 116 +++++++++++
 tb/tb_prbs_lfsr_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS LFSR generator: mode codes, FSM state type
// and maximal-length default tap masks for state widths 3..32.
package lfsr_pkg;

  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lfsr_state_e;

  // Fibonacci masks: bit (t-1) set for each tap t of a primitive polynomial.
  function automatic logic [31:0] default_ftaps(input int width);
    logic [31:0] m;
    m = 32'h0000_0000;
    case (width)
      3:       m = 32'h0000_0006;
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // Galois mask holds the same polynomial's low-order terms (x^t for t<n, plus x^0).
  function automatic logic [31:0] default_gtaps(input int width);
    logic [31:0] f;
    f = default_ftaps(width) & ~(32'h0000_0001 << (width - 1));
    return (f << 1) | 32'h0000_0001;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational one-step LFSR advance, Fibonacci or Galois form.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter int               MODE  = MODE_FIB,
  parameter logic [WIDTH-1:0] FTAPS = WIDTH'(default_ftaps(WIDTH)),
  parameter logic [WIDTH-1:0] GTAPS = WIDTH'(default_gtaps(WIDTH))
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  // Next state from the current state for the selected LFSR form
  always_comb begin
    nxt = {WIDTH{1'b0}};
    if (MODE == MODE_GAL) begin
      if (cur[WIDTH-1]) begin
        nxt = {cur[WIDTH-2:0], 1'b0} ^ GTAPS;
      end else begin
        nxt = {cur[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt = {cur[WIDTH-2:0], ^(cur & FTAPS)};
    end
  end

endmodule

// File: rtl/prbs_lfsr_gen.sv
// PRBS generator: LFSR with seed load, ready/valid stepping, wrap detection
// and period measurement.
module prbs_lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 5,
  parameter int               MODE         = MODE_FIB,
  parameter logic [WIDTH-1:0] FTAPS        = WIDTH'(default_ftaps(WIDTH)),
  parameter logic [WIDTH-1:0] GTAPS        = WIDTH'(default_gtaps(WIDTH)),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             bit_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  lfsr_state_e      state_r, state_nxt_s;
  logic [WIDTH-1:0] lfsr_r, start_r, count_r, period_r;
  logic [WIDTH-1:0] step_s, load_val_s, count_inc_s;
  logic             valid_r, wrap_r, lockup_r;
  logic             advance_s, seed_zero_s;

  lfsr_next #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .FTAPS (FTAPS),
    .GTAPS (GTAPS)
  ) u_next (
    .cur (lfsr_r),
    .nxt (step_s)
  );

  // Zero seeds would lock the LFSR, so they are replaced by the default seed
  assign seed_zero_s = (seed == CNT_ZERO);
  assign load_val_s  = seed_zero_s ? DEFAULT_SEED : seed;
  assign advance_s   = (state_r == RUN) && valid_r && out_ready && !load;
  assign count_inc_s = (count_r == CNT_MAX) ? CNT_MAX : (count_r + CNT_ONE);

  // FSM next-state: run follows the enable level
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_nxt_s = RUN;
        else        state_nxt_s = IDLE;
      end
      RUN: begin
        if (enable) state_nxt_s = RUN;
        else        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register with registered valid flag
  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s == RUN);
    end
  end

  // LFSR datapath: load beats advance; wrap/lockup are single-cycle pulses
  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      lfsr_r   <= DEFAULT_SEED;
      start_r  <= DEFAULT_SEED;
      count_r  <= CNT_ZERO;
      period_r <= CNT_ZERO;
      wrap_r   <= 1'b0;
      lockup_r <= 1'b0;
    end else begin
      wrap_r   <= 1'b0;
      lockup_r <= 1'b0;
      if (load) begin
        lfsr_r   <= load_val_s;
        start_r  <= load_val_s;
        count_r  <= CNT_ZERO;
        lockup_r <= seed_zero_s;
      end else if (advance_s) begin
        lfsr_r <= step_s;
        if (step_s == start_r) begin
          wrap_r   <= 1'b1;
          period_r <= count_inc_s;
          count_r  <= CNT_ZERO;
        end else begin
          count_r <= count_inc_s;
        end
      end
    end
  end

  assign out       = lfsr_r;
  assign out_valid = valid_r;
  assign bit_out   = lfsr_r[WIDTH-1];
  assign wrap      = wrap_r;
  assign lockup    = lockup_r;
  assign period    = period_r;

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Bench for prbs_lfsr_gen: Fibonacci and Galois instances side by side, a vector
// table, hand-written wrap/reset sequences and random traffic against a model.
module tb_prbs_lfsr_gen;

  logic       clk = 1'b0;
  logic       rset, load, enable, out_ready;
  logic [4:0] seed;
  logic [4:0] out_f, out_g, per_f, per_g;
  logic       val_f, val_g, bit_f, bit_g, wrap_f, wrap_g, lock_f, lock_g;

  always #5 clk = ~clk;

  prbs_lfsr_gen #(.WIDTH(5), .MODE(0), .FTAPS(5'b10100), .GTAPS(5'b01001),
                  .DEFAULT_SEED(5'b00001)) dut_fib (
    .clk(clk), .rset(rset), .load(load), .seed(seed), .enable(enable),
    .out_ready(out_ready), .out_valid(val_f), .out(out_f), .bit_out(bit_f),
    .wrap(wrap_f), .lockup(lock_f), .period(per_f));

  prbs_lfsr_gen #(.WIDTH(5), .MODE(1), .FTAPS(5'b10100), .GTAPS(5'b01001),
                  .DEFAULT_SEED(5'b00001)) dut_gal (
    .clk(clk), .rset(rset), .load(load), .seed(seed), .enable(enable),
    .out_ready(out_ready), .out_valid(val_g), .out(out_g), .bit_out(bit_g),
    .wrap(wrap_g), .lockup(lock_g), .period(per_g));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model, index 0 = Fibonacci, 1 = Galois
  int m_val[2], m_start[2], m_cnt[2], m_per[2];
  bit m_wrap[2], m_lock[2];
  bit m_run;

  function automatic int model_step(input int mode, input int v);
    int s;
    s = v * 2;
    if (mode == 0) return (s % 32) + ($countones(v & 32'h14) % 2);
    if (s >= 32) return (s - 32) ^ 9;
    return s;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_val[m] = 1; m_start[m] = 1; m_cnt[m] = 0; m_per[m] = 0;
      m_wrap[m] = 0; m_lock[m] = 0;
    end
    m_run = 0;
  endtask

  task automatic model_edge(input bit ld, input int sd, input bit en, input bit rd);
    bit adv;
    int nv, c1;
    adv = m_run && rd && !ld;
    for (int m = 0; m < 2; m++) begin
      m_wrap[m] = 0;
      m_lock[m] = 0;
      if (ld) begin
        m_val[m]   = (sd == 0) ? 1 : sd;
        m_lock[m]  = (sd == 0);
        m_start[m] = m_val[m];
        m_cnt[m]   = 0;
      end else if (adv) begin
        nv = model_step(m, m_val[m]);
        c1 = (m_cnt[m] >= 31) ? 31 : m_cnt[m] + 1;
        if (nv == m_start[m]) begin
          m_wrap[m] = 1; m_per[m] = c1; m_cnt[m] = 0;
        end else begin
          m_cnt[m] = c1;
        end
        m_val[m] = nv;
      end
    end
    m_run = en;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".fib.out"},    out_f,  m_val[0]);
    chk({tag, ".fib.valid"},  val_f,  m_run);
    chk({tag, ".fib.wrap"},   wrap_f, m_wrap[0]);
    chk({tag, ".fib.lockup"}, lock_f, m_lock[0]);
    chk({tag, ".fib.period"}, per_f,  m_per[0]);
    chk({tag, ".fib.bit"},    bit_f,  (m_val[0] >= 16));
    chk({tag, ".gal.out"},    out_g,  m_val[1]);
    chk({tag, ".gal.valid"},  val_g,  m_run);
    chk({tag, ".gal.wrap"},   wrap_g, m_wrap[1]);
    chk({tag, ".gal.lockup"}, lock_g, m_lock[1]);
    chk({tag, ".gal.period"}, per_g,  m_per[1]);
    chk({tag, ".gal.bit"},    bit_g,  (m_val[1] >= 16));
  endtask

  // Inputs change 1 time unit after an edge; outputs are read 1 unit after the next
  task automatic step_cycle(input bit ld, input logic [4:0] sd, input bit en, input bit rd);
    load = ld; seed = sd; enable = en; out_ready = rd;
    @(posedge clk);
    model_edge(ld, int'(sd), en, rd);
    #1;
  endtask

  task automatic do_reset();
    rset = 1'b1; load = 1'b0; seed = 5'd0; enable = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       ld;
    logic [4:0] sd;
    logic       en;
    logic       rd;
    logic [4:0] eout;
    logic       evalid;
    logic       ewrap;
    logic       elock;
  } vec_t;

  vec_t tbl[14];
  logic [4:0] gal_exp[5];
  bit en_r;

  initial begin
    tbl[0]  = '{1'b1, 5'b00001, 1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 5'b00010, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 5'b00100, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 5'b01001, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 5'b10010, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 5'b00101, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 5'b00000, 1'b1, 1'b0, 5'b00101, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 5'b00000, 1'b1, 1'b0, 5'b00101, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 5'b00000, 1'b1, 1'b0, 5'b00101, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 5'b01011, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 5'b00000, 1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 5'b00011, 1'b1, 1'b1, 5'b00011, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 5'b00000, 1'b0, 1'b1, 5'b00110, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 5'b00000, 1'b0, 1'b1, 5'b00110, 1'b0, 1'b0, 1'b0};
    gal_exp[0] = 5'b00010; gal_exp[1] = 5'b00100; gal_exp[2] = 5'b01000;
    gal_exp[3] = 5'b10000; gal_exp[4] = 5'b01001;

    rset = 1'b1; load = 1'b0; seed = 5'd0; enable = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rset = 1'b0;
    model_reset();
    #1;
    chk("reset.out",    out_f,  32'd1);
    chk("reset.valid",  val_f,  32'd0);
    chk("reset.wrap",   wrap_f, 32'd0);
    chk("reset.lockup", lock_f, 32'd0);
    chk("reset.period", per_f,  32'd0);
    check_model("reset");

    for (int i = 0; i < 14; i++) begin
      step_cycle(tbl[i].ld, tbl[i].sd, tbl[i].en, tbl[i].rd);
      chk($sformatf("vec%0d.out", i),    out_f,  tbl[i].eout);
      chk($sformatf("vec%0d.valid", i),  val_f,  tbl[i].evalid);
      chk($sformatf("vec%0d.wrap", i),   wrap_f, tbl[i].ewrap);
      chk($sformatf("vec%0d.lockup", i), lock_f, tbl[i].elock);
    end

    // Full period from seed 1 on both forms
    do_reset();
    step_cycle(1'b1, 5'b00001, 1'b1, 1'b1);
    for (int i = 1; i <= 31; i++) begin
      step_cycle(1'b0, 5'b00000, 1'b1, 1'b1);
      if (i <= 5) chk($sformatf("gal.seq%0d", i), out_g, gal_exp[i-1]);
      if (i == 30) chk("wrap.early", wrap_f, 32'd0);
      check_model($sformatf("wrap%0d", i));
    end
    chk("wrap.fib.pulse",  wrap_f, 32'd1);
    chk("wrap.fib.period", per_f,  32'd31);
    chk("wrap.fib.out",    out_f,  32'd1);
    chk("wrap.gal.pulse",  wrap_g, 32'd1);
    chk("wrap.gal.period", per_g,  32'd31);
    step_cycle(1'b0, 5'b00000, 1'b1, 1'b1);
    chk("wrap.fib.once",   wrap_f, 32'd0);
    chk("wrap.fib.hold",   per_f,  32'd31);
    chk("wrap.fib.after",  out_f,  32'd2);

    // Asynchronous reset between edges while running
    step_cycle(1'b0, 5'b00000, 1'b1, 1'b1);
    #2;
    rset = 1'b1; enable = 1'b0; load = 1'b1; seed = 5'b10101;
    #1;
    chk("areset.out",    out_f,  32'd1);
    chk("areset.valid",  val_f,  32'd0);
    chk("areset.wrap",   wrap_f, 32'd0);
    chk("areset.lockup", lock_f, 32'd0);
    chk("areset.period", per_f,  32'd0);
    chk("areset.gal",    out_g,  32'd1);
    #10;
    load = 1'b0;
    rset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step_cycle(1'b0, 5'b00000, 1'b0, 1'b1);
      check_model($sformatf("postrst%0d", i));
    end

    // Random traffic against the model
    do_reset();
    en_r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bit ld, rd;
      logic [4:0] sd;
      if ($urandom_range(0, 9) == 0) en_r = ~en_r;
      ld = ($urandom_range(0, 39) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 3) != 0);
      step_cycle(ld, sd, en_r, rd);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
